// File: rtl/instruction_encode.sv
// RV32 field packer: builds an instruction word from its fields, classifies immediate
// faults, and queues {err,instr} pairs in a small FIFO with valid/ready on both sides.
package common;
  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_LOAD_FP  = 7'h07;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_STORE_FP = 7'h27;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_MADD     = 7'h43;
  localparam logic [6:0] OPC_MSUB     = 7'h47;
  localparam logic [6:0] OPC_NMSUB    = 7'h4B;
  localparam logic [6:0] OPC_NMADD    = 7'h4F;
  localparam logic [6:0] OPC_OP_FP    = 7'h53;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_e;
  typedef enum logic [1:0] {ERR_OK, ERR_OPCODE, ERR_ALIGN, ERR_RANGE} err_e;

  typedef struct packed {
    logic [1:0]  err;
    logic [31:0] instr;
  } enc_word_t;

  function automatic fmt_e fmt_of(input logic [6:0] opc);
    fmt_e f;
    case (opc)
      OPC_OP, OPC_OP_FP, OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD: f = FMT_R;
      OPC_OP_IMM, OPC_JALR, OPC_LOAD, OPC_LOAD_FP, OPC_SYSTEM:     f = FMT_I;
      OPC_STORE, OPC_STORE_FP:                                     f = FMT_S;
      OPC_BRANCH:                                                  f = FMT_B;
      OPC_LUI, OPC_AUIPC:                                          f = FMT_U;
      OPC_JAL:                                                     f = FMT_J;
      default:                                                     f = FMT_X;
    endcase
    return f;
  endfunction
endpackage

module instruction_encode
  import common::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       func3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [1:0]       out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NW = AW + 1;

  fmt_e        w_fmt;
  logic [31:0] w_raw;
  logic        w_align_bad;
  logic        w_range_bad;
  err_e        w_err;
  enc_word_t   w_word;

  enc_word_t        r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [NW-1:0]    r_count;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [31:0]      r_out_instr;
  logic [1:0]       r_out_err;
  logic [CNT_W-1:0] r_enc_count;
  logic [CNT_W-1:0] r_err_count;

  logic             w_push;
  logic             w_pop;
  logic [NW-1:0]    w_count_nxt;
  enc_word_t        w_head_nxt;

  // Field packing and immediate checks; range holds when the bits above the field are a sign extension.
  always_comb begin
    w_fmt       = fmt_of(opcode);
    w_raw       = '0;
    w_align_bad = 1'b0;
    w_range_bad = 1'b0;
    case (w_fmt)
      FMT_R: w_raw = {funct7, rs2, rs1, func3, rd, opcode};
      FMT_I: begin
        w_raw       = {imm[11:0], rs1, func3, rd, opcode};
        w_range_bad = !((&imm[31:11]) || (~|imm[31:11]));
      end
      FMT_S: begin
        w_raw       = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
        w_range_bad = !((&imm[31:11]) || (~|imm[31:11]));
      end
      FMT_B: begin
        w_raw       = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
        w_align_bad = imm[0];
        w_range_bad = !((&imm[31:12]) || (~|imm[31:12]));
      end
      FMT_U: begin
        w_raw       = {imm[31:12], rd, opcode};
        w_align_bad = |imm[11:0];
      end
      FMT_J: begin
        w_raw       = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        w_align_bad = imm[0];
        w_range_bad = !((&imm[31:20]) || (~|imm[31:20]));
      end
      default: w_raw = '0;
    endcase

    if (w_fmt == FMT_X)   w_err = ERR_OPCODE;
    else if (w_align_bad) w_err = ERR_ALIGN;
    else if (w_range_bad) w_err = ERR_RANGE;
    else                  w_err = ERR_OK;

    w_word.err   = 2'(w_err);
    w_word.instr = (w_err == ERR_OK) ? w_raw : INSTR_NOP;
  end

  assign w_push      = in_valid && r_in_ready;
  assign w_pop       = r_out_valid && out_ready;
  assign w_count_nxt = r_count + NW'(w_push) - NW'(w_pop);

  // Next head: a popped slot is replaced by the following entry, or by the incoming word when that is the only one left.
  always_comb begin
    w_head_nxt.err   = r_out_err;
    w_head_nxt.instr = r_out_instr;
    if (w_pop) begin
      if (r_count > NW'(1))  w_head_nxt = r_mem[r_rd_ptr + AW'(1)];
      else if (w_push)       w_head_nxt = w_word;
      else                   w_head_nxt = '0;
    end else if ((r_count == '0) && w_push) begin
      w_head_nxt = w_word;
    end
  end

  // Storage array carries no reset; only the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_err   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt != NW'(DEPTH));
      r_out_valid <= (w_count_nxt != '0);
      r_out_instr <= w_head_nxt.instr;
      r_out_err   <= w_head_nxt.err;
    end
  end

  // Counters advance on pop; the error count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enc_count <= '0;
      r_err_count <= '0;
    end else if (w_pop) begin
      r_enc_count <= r_enc_count + CNT_W'(1);
      if ((r_out_err != 2'b00) && (r_err_count != '1))
        r_err_count <= r_err_count + CNT_W'(1);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_err   = r_out_err;
  assign enc_count = r_enc_count;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_instruction_encode.sv
// Directed bench for instruction_encode: encodings, error classes, FIFO ordering, backpressure and reset.
module tb_instruction_encode;
  import common::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  func3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [1:0]  out_err;
  logic [15:0] enc_count, err_count;

  int checks = 0;
  int errors = 0;

  instruction_encode #(.DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .func3(func3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] im);
    opcode = op; rd = d; rs1 = s1; rs2 = s2; func3 = f3; funct7 = f7; imm = im;
  endtask

  task automatic push_one(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                          input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] im);
    drive(op, d, s1, s2, f3, f7, im);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pop_one;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_out_instr got %h want 00000000", out_instr); end
    checks++; if (out_err !== 2'd0) begin errors++; $display("FAIL rst_out_err got %0d want 0", out_err); end
    checks++; if (enc_count !== 16'd0 || err_count !== 16'd0) begin errors++; $display("FAIL rst_counters got %0d/%0d want 0/0", enc_count, err_count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_op_imm;
    out_ready = 1'b1;
    drive(OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL opimm_latency got %b want 1", out_valid); end
    checks++; if (out_instr !== 32'h0050_0093) begin errors++; $display("FAIL opimm_instr got %h want 00500093", out_instr); end
    checks++; if (out_err !== 2'd0) begin errors++; $display("FAIL opimm_err got %0d want 0", out_err); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL opimm_drain got %b want 0", out_valid); end
    checks++; if (enc_count !== 16'd1) begin errors++; $display("FAIL opimm_enc got %0d want 1", enc_count); end
  endtask

  task automatic test_branch;
    out_ready = 1'b0;
    push_one(OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF8);
    checks++; if (out_instr !== 32'hFE20_8CE3 || out_err !== 2'd0) begin errors++; $display("FAIL br_ok got %h/%0d want fe208ce3/0", out_instr, out_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL br_ready1 got %b want 1", in_ready); end
    push_one(OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF9);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL br_full got %b want 0", in_ready); end
    checks++; if (out_instr !== 32'hFE20_8CE3) begin errors++; $display("FAIL br_head_hold got %h want fe208ce3", out_instr); end
    pop_one();
    checks++; if (out_instr !== 32'h0000_0013 || out_err !== 2'd2) begin errors++; $display("FAIL br_misalign got %h/%0d want 00000013/2", out_instr, out_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL br_ready2 got %b want 1", in_ready); end
    pop_one();
    checks++; if (out_valid !== 1'b0 || enc_count !== 16'd3 || err_count !== 16'd1) begin errors++; $display("FAIL br_counts got v%b %0d/%0d want v0 3/1", out_valid, enc_count, err_count); end
  endtask

  task automatic test_store;
    push_one(OPC_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd12);
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h0020_A623 || out_err !== 2'd0) begin errors++; $display("FAIL store got v%b %h/%0d want v1 0020a623/0", out_valid, out_instr, out_err); end
    pop_one();
    checks++; if (enc_count !== 16'd4) begin errors++; $display("FAIL store_enc got %0d want 4", enc_count); end
  endtask

  task automatic test_errors;
    push_one(OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    push_one(OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    checks++; if (out_instr !== 32'h0010_00EF || out_err !== 2'd0) begin errors++; $display("FAIL jal got %h/%0d want 001000ef/0", out_instr, out_err); end
    pop_one();
    checks++; if (out_instr !== 32'h0000_0013 || out_err !== 2'd3) begin errors++; $display("FAIL i_range got %h/%0d want 00000013/3", out_instr, out_err); end
    pop_one();
    push_one(7'h7F, 5'd1, 5'd2, 5'd3, 3'd1, 7'd0, 32'd0);
    checks++; if (out_instr !== 32'h0000_0013 || out_err !== 2'd1) begin errors++; $display("FAIL bad_opc got %h/%0d want 00000013/1", out_instr, out_err); end
    pop_one();
    checks++; if (err_count !== 16'd3) begin errors++; $display("FAIL err_cnt got %0d want 3", err_count); end
    push_one(OPC_AUIPC, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001);
    checks++; if (out_instr !== 32'h0000_0013 || out_err !== 2'd2) begin errors++; $display("FAIL u_align got %h/%0d want 00000013/2", out_instr, out_err); end
    pop_one();
    checks++; if (enc_count !== 16'd8 || err_count !== 16'd4) begin errors++; $display("FAIL err_totals got %0d/%0d want 8/4", enc_count, err_count); end
  endtask

  task automatic test_boundaries;
    logic [6:0]  v_op   [9] = '{OPC_OP_IMM, OPC_OP_IMM, OPC_BRANCH, OPC_BRANCH, OPC_JAL,
                               OPC_JAL, OPC_JAL, OPC_MADD, OPC_MISC_MEM};
    logic [31:0] v_imm  [9] = '{32'hFFFF_F800, 32'h0000_07FF, 32'd4094, 32'd4096, 32'h0010_0000,
                               32'hFFF0_0000, 32'h0010_0001, 32'd0, 32'd0};
    logic [4:0]  v_rd   [9] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd1};
    logic [4:0]  v_rs   [9] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd1};
    logic [31:0] v_exp  [9] = '{32'h8000_0013, 32'h7FF0_0013, 32'h7E00_0FE3, 32'h0000_0013,
                               32'h0000_0013, 32'h8000_006F, 32'h0000_0013, 32'h3020_81C3,
                               32'h0000_0013};
    logic [1:0]  v_err  [9] = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd2, 2'd0, 2'd1};
    for (int i = 0; i < 9; i++) begin
      push_one(v_op[i], v_rd[i], v_rs[i], (v_op[i] == OPC_MADD) ? 5'd2 : 5'd0, 3'd0,
               (v_op[i] == OPC_MADD) ? 7'b0011000 : 7'd0, v_imm[i]);
      checks++;
      if (out_valid !== 1'b1 || out_instr !== v_exp[i] || out_err !== v_err[i]) begin
        errors++;
        $display("FAIL bound[%0d] got v%b %h/%0d want v1 %h/%0d", i, out_valid, out_instr, out_err, v_exp[i], v_err[i]);
      end
      pop_one();
    end
    checks++; if (enc_count !== 16'd17 || err_count !== 16'd8) begin errors++; $display("FAIL bound_counts got %0d/%0d want 17/8", enc_count, err_count); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] popped [3];
    int npop = 0;
    int nacc = 0;
    logic pre_valid;
    logic [31:0] pre_instr;
    logic acc;
    out_ready = 1'b0;
    push_one(OPC_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %b want 1", in_ready); end
    push_one(OPC_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got %b want 0", in_ready); end
    drive(OPC_LUI, 5'd1, 5'd31, 5'd31, 3'd7, 7'h7F, 32'hFFFF_F000);
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && npop < 3; cyc++) begin
      pre_valid = out_valid;
      pre_instr = out_instr;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (pre_valid) begin popped[npop] = pre_instr; npop++; end
      if (acc) begin in_valid = 1'b0; nacc++; end
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (npop != 3) begin
      errors++; $display("FAIL b2b_timeout got %0d pops want 3", npop);
    end else begin
      checks++; if (popped[0] !== 32'h1234_52B7) begin errors++; $display("FAIL b2b_w0 got %h want 123452b7", popped[0]); end
      checks++; if (popped[1] !== 32'h0020_81B3) begin errors++; $display("FAIL b2b_w1 got %h want 002081b3", popped[1]); end
      checks++; if (popped[2] !== 32'hFFFF_F0B7) begin errors++; $display("FAIL b2b_w2 got %h want fffff0b7", popped[2]); end
    end
    checks++; if (nacc != 1) begin errors++; $display("FAIL b2b_accept got %0d want 1", nacc); end
    checks++; if (enc_count !== 16'd20 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_enc got %0d v%b want 20 v0", enc_count, out_valid); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    push_one(OPC_OP_IMM, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd7);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0) begin errors++; $display("FAIL mid_flush got v%b %h want v0 00000000", out_valid, out_instr); end
    checks++; if (enc_count !== 16'd0 || err_count !== 16'd0) begin errors++; $display("FAIL mid_counters got %0d/%0d want 0/0", enc_count, err_count); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    push_one(OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h0050_0093 || out_err !== 2'd0) begin errors++; $display("FAIL mid_repush got v%b %h/%0d want v1 00500093/0", out_valid, out_instr, out_err); end
    pop_one();
    checks++; if (enc_count !== 16'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_enc got %0d v%b want 1 v0", enc_count, out_valid); end
  endtask

  initial begin
    test_reset();
    test_op_imm();
    test_branch();
    test_store();
    test_errors();
    test_boundaries();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
